// File: rtl/ps2_keypad_if.sv
// PS/2 keypad bundle: raw PS/2 pins in, Chip-8 key state and strobes out.
// master = keypad decoder, slave = PS/2 source / chip8 consumer.
interface ps2_keypad_if;
  logic        ps2_clk;
  logic        ps2_data;
  logic [15:0] keys;
  logic        key_down;
  logic [3:0]  key_code;
  logic        frame_err;

  modport master (input ps2_clk, ps2_data, output keys, key_down, key_code, frame_err);
  modport slave  (output ps2_clk, ps2_data, input keys, key_down, key_code, frame_err);
endinterface

// File: rtl/ps2_keypad.sv
// PS/2 set-2 receiver and decoder driving the Chip-8 hex keypad state.
// Optional KEYPAD_ARROWS_EN: E0-prefixed arrow keys also drive keys 2/8/4/6.
module ps2_keypad #(
  parameter int unsigned CLK_HZ  = 25000000,
  parameter int unsigned TIMEOUT = CLK_HZ / 5000
) (
  input  logic          clk,
  input  logic          res,
  ps2_keypad_if.master  bus
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_e;

  logic          clk_s1_q, clk_s2_q, clk_prev_q, dat_s1_q, dat_s2_q;
  state_e        state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_q, to_d;
  logic          byte_valid_q, byte_valid_d;
  logic [7:0]    byte_q, byte_d;
  logic          frame_err_q, frame_err_d;
  logic          brk_q, brk_d, ext_q, ext_d;
  logic [15:0]   letter_q, letter_d, keys_q, keys_d;
  logic          key_down_q, key_down_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          fall;
`ifdef KEYPAD_ARROWS_EN
  logic [15:0]   arrow_q, arrow_d;
`endif

  assign fall = clk_prev_q & ~clk_s2_q;

  function automatic logic [4:0] map_letter(input logic [7:0] c);
    case (c)
      8'h16: return {1'b1, 4'h1};
      8'h1E: return {1'b1, 4'h2};
      8'h26: return {1'b1, 4'h3};
      8'h25: return {1'b1, 4'hC};
      8'h15: return {1'b1, 4'h4};
      8'h1D: return {1'b1, 4'h5};
      8'h24: return {1'b1, 4'h6};
      8'h2D: return {1'b1, 4'hD};
      8'h1C: return {1'b1, 4'h7};
      8'h1B: return {1'b1, 4'h8};
      8'h23: return {1'b1, 4'h9};
      8'h2B: return {1'b1, 4'hE};
      8'h1A: return {1'b1, 4'hA};
      8'h22: return {1'b1, 4'h0};
      8'h21: return {1'b1, 4'hB};
      8'h2A: return {1'b1, 4'hF};
      default: return 5'd0;
    endcase
  endfunction

`ifdef KEYPAD_ARROWS_EN
  function automatic logic [4:0] map_arrow(input logic [7:0] c);
    case (c)
      8'h75: return {1'b1, 4'h2};
      8'h72: return {1'b1, 4'h8};
      8'h6B: return {1'b1, 4'h4};
      8'h74: return {1'b1, 4'h6};
      default: return 5'd0;
    endcase
  endfunction
`endif

  // Frame receiver: start, 8 data LSB first, odd parity, stop; idle timeout aborts.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    to_d         = to_q;
    byte_valid_d = 1'b0;
    byte_d       = byte_q;
    frame_err_d  = 1'b0;
    if (state_q != S_IDLE) to_d = fall ? '0 : to_q + TW'(1);
    case (state_q)
      S_IDLE: begin
        to_d = '0;
        if (fall && !dat_s2_q) begin
          state_d   = S_DATA;
          bit_cnt_d = 4'd1;
        end
      end
      S_DATA: if (fall) begin
        shift_d   = {dat_s2_q, shift_q[7:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
        if (bit_cnt_q == 4'd8) state_d = S_PARITY;
      end
      S_PARITY: if (fall) begin
        par_d     = dat_s2_q;
        bit_cnt_d = 4'd10;
        state_d   = S_STOP;
      end
      S_STOP: if (fall) begin
        state_d   = S_IDLE;
        bit_cnt_d = 4'd0;
        if ((^{shift_q, par_q}) && dat_s2_q) begin
          byte_valid_d = 1'b1;
          byte_d       = shift_q;
        end else begin
          frame_err_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_q != S_IDLE && !fall && to_q == TW'(TIMEOUT - 1)) begin
      state_d     = S_IDLE;
      bit_cnt_d   = 4'd0;
      to_d        = '0;
      frame_err_d = 1'b1;
    end
  end

  // Decoder: prefix flags, make/break tracking, key-press strobe.
  always_comb begin
    logic [4:0] lk;
    lk         = 5'd0;
    brk_d      = brk_q;
    ext_d      = ext_q;
    letter_d   = letter_q;
    key_down_d = 1'b0;
    key_code_d = key_code_q;
`ifdef KEYPAD_ARROWS_EN
    arrow_d    = arrow_q;
`endif
    if (byte_valid_q) begin
      if (byte_q == 8'hF0) begin
        brk_d = 1'b1;
      end else if (byte_q == 8'hE0) begin
        ext_d = 1'b1;
      end else begin
        brk_d = 1'b0;
        ext_d = 1'b0;
        if (!ext_q) begin
          lk = map_letter(byte_q);
          if (lk[4]) letter_d[lk[3:0]] = ~brk_q;
        end
`ifdef KEYPAD_ARROWS_EN
        else begin
          lk = map_arrow(byte_q);
          if (lk[4]) arrow_d[lk[3:0]] = ~brk_q;
        end
`endif
        if (lk[4] && !brk_q) begin
          key_down_d = 1'b1;
          key_code_d = lk[3:0];
        end
      end
    end
`ifdef KEYPAD_ARROWS_EN
    keys_d = letter_d | arrow_d;
`else
    keys_d = letter_d;
`endif
  end

  always_ff @(posedge clk) begin
    if (res) begin
      clk_s1_q     <= 1'b1;
      clk_s2_q     <= 1'b1;
      clk_prev_q   <= 1'b1;
      dat_s1_q     <= 1'b1;
      dat_s2_q     <= 1'b1;
      state_q      <= S_IDLE;
      bit_cnt_q    <= 4'd0;
      shift_q      <= 8'd0;
      par_q        <= 1'b0;
      to_q         <= '0;
      byte_valid_q <= 1'b0;
      byte_q       <= 8'd0;
      frame_err_q  <= 1'b0;
      brk_q        <= 1'b0;
      ext_q        <= 1'b0;
      letter_q     <= 16'd0;
      keys_q       <= 16'd0;
      key_down_q   <= 1'b0;
      key_code_q   <= 4'd0;
`ifdef KEYPAD_ARROWS_EN
      arrow_q      <= 16'd0;
`endif
    end else begin
      clk_s1_q     <= bus.ps2_clk;
      clk_s2_q     <= clk_s1_q;
      clk_prev_q   <= clk_s2_q;
      dat_s1_q     <= bus.ps2_data;
      dat_s2_q     <= dat_s1_q;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      to_q         <= to_d;
      byte_valid_q <= byte_valid_d;
      byte_q       <= byte_d;
      frame_err_q  <= frame_err_d;
      brk_q        <= brk_d;
      ext_q        <= ext_d;
      letter_q     <= letter_d;
      keys_q       <= keys_d;
      key_down_q   <= key_down_d;
      key_code_q   <= key_code_d;
`ifdef KEYPAD_ARROWS_EN
      arrow_q      <= arrow_d;
`endif
    end
  end

  assign bus.keys      = keys_q;
  assign bus.key_down  = key_down_q;
  assign bus.key_code  = key_code_q;
  assign bus.frame_err = frame_err_q;

endmodule
